// File: rtl/lpc_capture_ctrl.sv
// LPC capture scheduler: filters decoded I/O cycles into a FIFO and serializes
// each stored entry as a 4-byte frame on a valid/ready byte stream.
module lpc_capture_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       lpc_clk,
    input  logic                       lpc_reset,
    input  logic                       cyc_valid,
    input  logic                       cyc_mode,
    input  logic                       cyc_direction,
    input  logic [15:0]                cyc_addr,
    input  logic [7:0]                 cyc_data,
    input  logic                       enable,
    input  logic                       cap_reads,
    input  logic                       cap_writes,
    input  logic [15:0]                addr_base,
    input  logic [15:0]                addr_mask,
    output logic [7:0]                 out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 overflow_count,
    output logic                       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {StIdle, StB0, StB1, StB2, StB3} state_e;

    state_e          state_q;
    logic [25:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [7:0]      ovf_q;
    logic [25:0]     shadow_q;

    logic            addr_hit;
    logic            dir_hit;
    logic            accept;
    logic            full;
    logic            push;
    logic            pop;
    logic [25:0]     head;

    always_comb begin
        addr_hit = (cyc_addr & addr_mask) == (addr_base & addr_mask);
        dir_hit  = cyc_direction ? cap_writes : cap_reads;
        accept   = cyc_valid && enable && addr_hit && dir_hit;
        // Fullness uses the registered level; a same-cycle pop never frees room.
        full     = level_q == LW'(DEPTH);
        push     = accept && !full;
        pop      = (state_q == StIdle) && (level_q != '0);
        head     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge lpc_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cyc_mode, cyc_direction, cyc_addr, cyc_data};
        end
    end

    always_ff @(posedge lpc_clk) begin
        if (!lpc_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (accept && full && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // Shadow layout: {mode, direction, addr[15:0], data[7:0]}.
    always_ff @(posedge lpc_clk) begin
        if (!lpc_reset) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shadow_q  <= head;
                        state_q   <= StB0;
                        out_valid <= 1'b1;
                        out_byte  <= {4'hA, 2'b00, head[25:24]};
                    end
                end
                StB0: begin
                    if (out_ready) begin
                        state_q  <= StB1;
                        out_byte <= shadow_q[23:16];
                    end
                end
                StB1: begin
                    if (out_ready) begin
                        state_q  <= StB2;
                        out_byte <= shadow_q[15:8];
                    end
                end
                StB2: begin
                    if (out_ready) begin
                        state_q  <= StB3;
                        out_byte <= shadow_q[7:0];
                    end
                end
                StB3: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                    out_byte  <= 8'h00;
                end
            endcase
        end
    end

    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
    assign busy           = (level_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Bench for lpc_capture_ctrl: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed byte sequences.
module tb_lpc_capture_ctrl;

    localparam int unsigned DEPTH = 8;

    logic        lpc_clk = 1'b0;
    logic        lpc_reset = 1'b0;
    logic        cyc_valid = 1'b0;
    logic        cyc_mode = 1'b1;
    logic        cyc_direction = 1'b1;
    logic [15:0] cyc_addr = '0;
    logic [7:0]  cyc_data = '0;
    logic        enable = 1'b1;
    logic        cap_reads = 1'b0;
    logic        cap_writes = 1'b1;
    logic [15:0] addr_base = '0;
    logic [15:0] addr_mask = '0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]  overflow_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lpc_capture_ctrl #(.DEPTH(DEPTH)) dut (
        .lpc_clk        (lpc_clk),
        .lpc_reset      (lpc_reset),
        .cyc_valid      (cyc_valid),
        .cyc_mode       (cyc_mode),
        .cyc_direction  (cyc_direction),
        .cyc_addr       (cyc_addr),
        .cyc_data       (cyc_data),
        .enable         (enable),
        .cap_reads      (cap_reads),
        .cap_writes     (cap_writes),
        .addr_base      (addr_base),
        .addr_mask      (addr_mask),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    always #5 lpc_clk = ~lpc_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: stored entries and the bytes still owed for the frame in flight.
    logic [25:0] m_fifo [$];
    logic [7:0]  m_frame [$];
    int          m_ovf = 0;
    bit          m_live = 0;
    int          m_pre;
    bit          m_acc;
    logic [25:0] m_e;

    always @(posedge lpc_clk) begin
        if (!lpc_reset) begin
            m_fifo.delete();
            m_frame.delete();
            m_ovf  = 0;
            m_live = 1;
        end else if (m_live) begin
            m_pre = m_fifo.size();
            m_acc = cyc_valid && enable &&
                    ((cyc_addr & addr_mask) == (addr_base & addr_mask)) &&
                    (cyc_direction ? cap_writes : cap_reads);
            if (m_frame.size() == 0) begin
                if (m_pre > 0) begin
                    m_e = m_fifo.pop_front();
                    m_frame = '{{4'hA, 2'b00, m_e[25:24]}, m_e[23:16], m_e[15:8], m_e[7:0]};
                end
            end else if (out_ready) begin
                void'(m_frame.pop_front());
            end
            if (m_acc) begin
                if (m_pre < DEPTH) m_fifo.push_back({cyc_mode, cyc_direction, cyc_addr, cyc_data});
                else if (m_ovf < 255) m_ovf++;
            end
        end
    end

    always @(negedge lpc_clk) begin
        if (m_live) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_frame.size() != 0});
            if (m_frame.size() != 0) chk("out_byte", {24'b0, out_byte}, {24'b0, m_frame[0]});
            chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
            chk("overflow_count", {24'b0, overflow_count}, 32'(m_ovf));
            chk("busy", {31'b0, busy}, {31'b0, (m_fifo.size() != 0) || (m_frame.size() != 0)});
        end
    end

    // Transferred bytes; the handshake completes at the following rising edge.
    logic [7:0] log_q [$];
    always @(negedge lpc_clk) begin
        if (lpc_reset && out_valid && out_ready) log_q.push_back(out_byte);
    end

    task automatic step();
        @(posedge lpc_clk);
        #1;
    endtask

    task automatic strobe(input logic m, input logic d, input logic [15:0] a, input logic [7:0] dat);
        cyc_mode = m;
        cyc_direction = d;
        cyc_addr = a;
        cyc_data = dat;
        cyc_valid = 1'b1;
        @(posedge lpc_clk);
        #1;
        cyc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge lpc_clk);
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
        step();
    endtask

    task automatic chk_frame(input string name, input int base, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        if (log_q.size() >= base + 4) begin
            chk({name, "_b0"}, {24'b0, log_q[base]},   {24'b0, b0});
            chk({name, "_b1"}, {24'b0, log_q[base+1]}, {24'b0, b1});
            chk({name, "_b2"}, {24'b0, log_q[base+2]}, {24'b0, b2});
            chk({name, "_b3"}, {24'b0, log_q[base+3]}, {24'b0, b3});
        end else begin
            chk({name, "_len"}, 32'(log_q.size()), 32'(base + 4));
        end
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge lpc_clk);
        #1;
        lpc_reset = 1'b1;
        @(negedge lpc_clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", {24'b0, overflow_count}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_byte", {24'b0, out_byte}, 32'h00);
        repeat (20) @(negedge lpc_clk);
        chk("idle_nothing", 32'(log_q.size()), 32'd0);

        // Single write capture, 2 cycles strobe to first byte
        step();
        log_q.delete();
        strobe(1'b1, 1'b1, 16'h0080, 8'h5A);
        @(negedge lpc_clk);
        chk("lat_k_valid", {31'b0, out_valid}, 32'd0);
        chk("lat_k_level", 32'(fifo_level), 32'd1);
        @(negedge lpc_clk);
        chk("lat_k1_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_k1_byte", {24'b0, out_byte}, 32'hA3);
        chk("lat_k1_level", 32'(fifo_level), 32'd0);
        repeat (3) @(negedge lpc_clk);
        chk("b3_byte", {24'b0, out_byte}, 32'h5A);
        @(negedge lpc_clk);
        chk("post_b3_valid", {31'b0, out_valid}, 32'd0);
        wait_idle(50);
        chk_frame("single", 0, 8'hA3, 8'h00, 8'h80, 8'h5A);
        chk("single_len", 32'(log_q.size()), 32'd4);

        // Filter
        log_q.delete();
        addr_base = 16'h0080;
        addr_mask = 16'hFFF0;
        cap_reads = 1'b0;
        strobe(1'b1, 1'b1, 16'h0085, 8'h11);
        strobe(1'b1, 1'b1, 16'h0090, 8'h22);
        strobe(1'b1, 1'b0, 16'h0081, 8'h33);
        wait_idle(50);
        chk("filter_len", 32'(log_q.size()), 32'd4);
        chk_frame("filter", 0, 8'hA3, 8'h00, 8'h85, 8'h11);
        chk("filter_ovf", {24'b0, overflow_count}, 32'd0);

        // Backpressure during B1
        addr_mask = 16'h0000;
        log_q.delete();
        out_ready = 1'b0;
        strobe(1'b1, 1'b1, 16'h0042, 8'h77);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge lpc_clk);
            chk("bp_hold_byte", {24'b0, out_byte}, 32'h00);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        step();
        out_ready = 1'b1;
        wait_idle(50);
        chk_frame("bp", 0, 8'hA3, 8'h00, 8'h42, 8'h77);

        // Overflow and wrap
        log_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) strobe(1'b1, 1'b1, 16'h0010, 8'(i));
        @(negedge lpc_clk);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_count", {24'b0, overflow_count}, 32'd3);
        step();
        out_ready = 1'b1;
        wait_idle(200);
        chk("ovf_len", 32'(log_q.size()), 32'd36);
        for (int i = 0; i < 9; i++) begin
            if (log_q.size() >= 4 * i + 4) chk("ovf_order", {24'b0, log_q[4*i+3]}, 32'(i));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 309; i++) strobe(1'b0, 1'b1, 16'h0020, 8'(i));
        @(negedge lpc_clk);
        chk("ovf_sat", {24'b0, overflow_count}, 32'hFF);
        step();
        out_ready = 1'b1;
        wait_idle(200);
        chk("ovf_sat_hold", {24'b0, overflow_count}, 32'hFF);

        // Reset mid-frame
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1, 16'h0100 + 16'(i), 8'hC0 + 8'(i));
        out_ready = 1'b1;
        @(posedge lpc_clk);
        @(posedge lpc_clk);
        #1;
        out_ready = 1'b0;
        @(negedge lpc_clk);
        chk("mid_b2_byte", {24'b0, out_byte}, 32'h00);
        chk("mid_level", 32'(fifo_level), 32'd3);
        step();
        lpc_reset = 1'b0;
        step();
        lpc_reset = 1'b1;
        @(negedge lpc_clk);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_byte", {24'b0, out_byte}, 32'h00);
        step();
        log_q.delete();
        out_ready = 1'b1;
        repeat (20) @(negedge lpc_clk);
        chk("mid_no_bytes", 32'(log_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
